i2c_apb_fifo: RTL and testbench

- Synchronous show-ahead (first-word-fall-through) FIFO between the APB slave front-end and the I2C core; one instance per direction.
- TX instance: APB write port (address 0) pushes into it and the I2C core pops.
- RX instance: the I2C core pushes into it and the APB read port (address 4) pops.
- Head word is visible on RD_DATA with no latency, so the APB read returns data in the same PENABLE cycle that pops it.

---
 rtl/i2c_apb_pkg.sv | 15 +
 rtl/i2c_fifo_mem.sv | 27 ++
 rtl/i2c_apb_fifo.sv | 94 +++++++++
 tb/tb_i2c_apb_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_apb_pkg.sv
// Shared constants and types for the I2C APB peripheral.
// FIFO geometry, APB register map and the FIFO word type.
package i2c_apb_pkg;

    localparam int I2C_FIFO_DWIDTH = 32;
    localparam int I2C_FIFO_AWIDTH = 4;

    localparam logic [3:0] ADDR_TX      = 4'd0;
    localparam logic [3:0] ADDR_RX      = 4'd4;
    localparam logic [3:0] ADDR_CFG     = 4'd8;
    localparam logic [3:0] ADDR_TIMEOUT = 4'd12;

    typedef logic [31:0] fifo_word_t;

endpackage : i2c_apb_pkg

// File: rtl/i2c_fifo_mem.sv
// Simple dual-port register array for the I2C FIFOs.
// Synchronous write, asynchronous read, no reset on storage.
module i2c_fifo_mem
    import i2c_apb_pkg::*;
#(
    parameter int DWIDTH = I2C_FIFO_DWIDTH,
    parameter int AWIDTH = I2C_FIFO_AWIDTH
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [2**AWIDTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : i2c_fifo_mem

// File: rtl/i2c_apb_fifo.sv
// Show-ahead FIFO between the APB front-end and the I2C core.
// Pointer/flag controller around an i2c_fifo_mem storage array.
module i2c_apb_fifo
    import i2c_apb_pkg::*;
#(
    parameter int DWIDTH      = I2C_FIFO_DWIDTH,
    parameter int AWIDTH      = I2C_FIFO_AWIDTH,
    parameter int AFULL_LEVEL = 12
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              CLEAR,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WR_DATA,
    input  logic              RD_ENA,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic [AWIDTH:0]   LEVEL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam logic [AWIDTH:0] AFULL_THRESH = AFULL_LEVEL[AWIDTH:0];

    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_rd_ptr;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic [AWIDTH:0]   w_level;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_mem_wr_en;
    logic [DWIDTH-1:0] w_mem_rdata;

    // The extra pointer MSB distinguishes full from empty when low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AWIDTH-1:0] == r_rd_ptr[AWIDTH-1:0]) &&
                     (r_wr_ptr[AWIDTH] != r_rd_ptr[AWIDTH]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign w_flush     = ~PRESETn | CLEAR;
    assign w_push      = WR_ENA & (~w_full | RD_ENA);
    assign w_pop       = RD_ENA & ~w_empty;
    assign w_mem_wr_en = w_push & ~w_flush;

    always_ff @(posedge PCLK) begin
        if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (WR_ENA && w_full && !RD_ENA) begin
                r_overflow <= 1'b1;
            end
            if (RD_ENA && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .i_clk     (PCLK),
        .i_wr_en   (w_mem_wr_en),
        .i_wr_addr (r_wr_ptr[AWIDTH-1:0]),
        .i_wr_data (WR_DATA),
        .i_rd_addr (r_rd_ptr[AWIDTH-1:0]),
        .o_rd_data (w_mem_rdata)
    );

    assign RD_DATA     = w_empty ? '0 : w_mem_rdata;
    assign EMPTY       = w_empty;
    assign FULL        = w_full;
    assign ALMOST_FULL = (w_level >= AFULL_THRESH);
    assign LEVEL       = w_level;
    assign OVERFLOW    = r_overflow;
    assign UNDERFLOW   = r_underflow;

endmodule : i2c_apb_fifo

// File: tb/tb_i2c_apb_fifo.sv
// Bench for i2c_apb_fifo: directed scenarios plus random traffic,
// checked against a queue-based model of the FIFO behaviour.
module tb_i2c_apb_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic        clk;
    logic        presetN;
    logic        clear;
    logic        wrEna;
    logic [31:0] wrData;
    logic        rdEna;
    logic [31:0] rdData;
    logic        empty;
    logic        full;
    logic        almostFull;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    logic [31:0] modelQ[$];
    bit          modelOvf;
    bit          modelUnf;

    int total;
    int bad;

    i2c_apb_fifo #(
        .DWIDTH      (32),
        .AWIDTH      (4),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .PCLK        (clk),
        .PRESETn     (presetN),
        .CLEAR       (clear),
        .WR_ENA      (wrEna),
        .WR_DATA     (wrData),
        .RD_ENA      (rdEna),
        .RD_DATA     (rdData),
        .EMPTY       (empty),
        .FULL        (full),
        .ALMOST_FULL (almostFull),
        .LEVEL       (level),
        .OVERFLOW    (overflow),
        .UNDERFLOW   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model; called at the falling edge.
    task automatic checkOutput(input string tag);
        int n;
        n = modelQ.size();
        checkVal({tag, ".rd_data"}, rdData, (n > 0) ? modelQ[0] : 32'h0);
        checkVal({tag, ".level"}, {27'h0, level}, n);
        checkVal({tag, ".empty"}, {31'h0, empty}, {31'h0, n == 0});
        checkVal({tag, ".full"}, {31'h0, full}, {31'h0, n == DEPTH});
        checkVal({tag, ".afull"}, {31'h0, almostFull}, {31'h0, n >= AFULL});
        checkVal({tag, ".overflow"}, {31'h0, overflow}, {31'h0, modelOvf});
        checkVal({tag, ".underflow"}, {31'h0, underflow}, {31'h0, modelUnf});
    endtask

    // Drive one cycle from a falling edge, update the model at the rising edge.
    task automatic applyStimulus(input bit wr, input logic [31:0] wd, input bit rd,
                                 input bit clr, input bit rstN);
        bit isFull;
        bit isEmpty;
        wrEna   = wr;
        wrData  = wd;
        rdEna   = rd;
        clear   = clr;
        presetN = rstN;
        @(posedge clk);
        if (!rstN || clr) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            isFull  = (modelQ.size() == DEPTH);
            isEmpty = (modelQ.size() == 0);
            if (wr && isFull && !rd) modelOvf = 1'b1;
            if (rd && isEmpty) modelUnf = 1'b1;
            if (rd && !isEmpty) void'(modelQ.pop_front());
            if (wr && (!isFull || rd)) modelQ.push_back(wd);
        end
        @(negedge clk);
        wrEna = 1'b0;
        rdEna = 1'b0;
        clear = 1'b0;
        presetN = 1'b1;
    endtask

    task automatic fillToOverflow(input logic [31:0] base);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, base + i, 0, 0, 1);
        applyStimulus(1, 32'hDEAD, 0, 0, 1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        presetN  = 1'b0;
        clear    = 1'b0;
        wrEna    = 1'b0;
        rdEna    = 1'b0;
        wrData   = '0;
        @(negedge clk);

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset");
        checkVal("reset.rd_zero", rdData, 32'h0);

        applyStimulus(1, 32'hA5A5_0001, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("single");
        checkVal("single.head", rdData, 32'hA5A5_0001);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("single_pop");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, i, 0, 0, 1);
            checkOutput("fill");
        end
        checkVal("fill.level16", {27'h0, level}, 32'd16);
        applyStimulus(1, 32'hDEAD, 0, 0, 1);
        checkOutput("overflow");
        checkVal("overflow.flag", {31'h0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            checkVal("drain.order", rdData, i);
            applyStimulus(0, 0, 1, 0, 1);
            checkOutput("drain");
        end

        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, i, 0, 0, 1);
        checkVal("fullrw.head", rdData, 32'h0);
        applyStimulus(1, 32'h100, 1, 0, 1);
        checkOutput("fullrw");
        checkVal("fullrw.ovf0", {31'h0, overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("wrap");
            applyStimulus(0, 0, 1, 0, 1);
        end
        checkOutput("wrap_end");

        applyStimulus(1, 32'h55, 1, 0, 1);
        checkOutput("emptyrw");
        checkVal("emptyrw.data", rdData, 32'h55);
        checkVal("emptyrw.unf", {31'h0, underflow}, 32'd1);

        applyStimulus(0, 0, 0, 1, 1);
        fillToOverflow(32'h200);
        for (int i = 0; i < 11; i++) applyStimulus(0, 0, 1, 0, 1);
        checkOutput("pre_clear");
        applyStimulus(1, 32'h77, 0, 1, 1);
        checkOutput("clear");
        checkVal("clear.level", {27'h0, level}, 32'd0);

        fillToOverflow(32'h300);
        for (int i = 0; i < 11; i++) applyStimulus(0, 0, 1, 0, 1);
        checkOutput("pre_reset");
        applyStimulus(1, 32'h88, 0, 0, 0);
        checkOutput("midreset");
        checkVal("midreset.empty", {31'h0, empty}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            bit wr;
            bit rd;
            bit clr;
            bit rst;
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 99) < 1);
            applyStimulus(wr, $urandom, rd, clr, !rst);
            checkOutput("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_i2c_apb_fifo
